// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory wait and watchdog.
// Optional perf counters are enabled by defining HAZARD_CTRL_PERF_EN.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_id_rs1_addr,
  input  logic [4:0]  i_id_rs2_addr,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic [4:0]  i_ex_rd_addr,
  input  logic        i_ex_DM_OE,
  input  logic        i_ex_branch_taken,
  input  logic        i_dm_req,
  input  logic        i_dm_ready,
  output logic        o_pc_hold,
  output logic        o_if_id_hold,
  output logic        o_id_ex_hold,
  output logic        o_ex_mem_hold,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic [1:0]  o_state,
  output logic        o_mem_timeout,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_TIMEOUT  = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_pending_flush;
  logic [7:0] r_wait_cnt;
  logic       r_mem_timeout;

  logic w_load_use;
  logic w_hold_all;
  logic w_flush;
  logic w_bubble;

  assign w_load_use = i_ex_DM_OE && (i_ex_rd_addr != 5'd0) &&
                      ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
                       (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));

  // Memory wait dominates branch flush, which dominates the load-use bubble.
  always_comb begin
    w_hold_all = 1'b0;
    w_flush    = 1'b0;
    w_bubble   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_RUN: begin
          if (i_dm_req && !i_dm_ready)  w_hold_all = 1'b1;
          else if (i_ex_branch_taken)   w_flush    = 1'b1;
          else if (w_load_use)          w_bubble   = 1'b1;
        end
        S_MEM_WAIT: begin
          if (!i_dm_ready)                                w_hold_all = 1'b1;
          else if (r_pending_flush || i_ex_branch_taken)  w_flush    = 1'b1;
          else if (w_load_use)                            w_bubble   = 1'b1;
        end
        S_TIMEOUT: w_hold_all = 1'b1;
        default: begin
          w_hold_all = 1'b0;
        end
      endcase
    end
  end

  assign o_pc_hold     = w_hold_all | w_bubble;
  assign o_if_id_hold  = w_hold_all | w_bubble;
  assign o_id_ex_hold  = w_hold_all;
  assign o_ex_mem_hold = w_hold_all;
  assign o_if_id_flush = w_flush;
  assign o_id_ex_flush = w_flush | w_bubble;
  assign o_state       = r_state;
  assign o_mem_timeout = r_mem_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_RUN;
      r_pending_flush <= 1'b0;
      r_wait_cnt      <= 8'd0;
      r_mem_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_dm_req && !i_dm_ready) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        S_MEM_WAIT: begin
          if (!i_dm_ready) begin
            if (i_ex_branch_taken)
              r_pending_flush <= 1'b1;
            // A full count of 255 with memory still busy means the access is lost.
            if (r_wait_cnt == 8'hFF) begin
              r_state       <= S_TIMEOUT;
              r_mem_timeout <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + 8'd1;
            end
          end else begin
            r_state         <= S_RUN;
            r_pending_flush <= 1'b0;
          end
        end
        S_TIMEOUT: r_state <= S_TIMEOUT;
        default:   r_state <= S_RUN;
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (o_pc_hold)     r_stall_cnt <= r_stall_cnt + 32'd1;
      if (o_id_ex_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = 32'd0;
  assign o_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        u1 = 1'b0, u2 = 1'b0, oe = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
  logic        pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
    .i_id_rs1_used(u1), .i_id_rs2_used(u2),
    .i_ex_rd_addr(rd), .i_ex_DM_OE(oe), .i_ex_branch_taken(br),
    .i_dm_req(req), .i_dm_ready(rdy),
    .o_pc_hold(pc_hold), .o_if_id_hold(if_id_hold),
    .o_id_ex_hold(id_ex_hold), .o_ex_mem_hold(ex_mem_hold),
    .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
    .o_state(state), .o_mem_timeout(mem_timeout),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: mode 0 running, 1 waiting on memory, 2 dead; wc counts busy wait cycles.
  int          m_mode = 0;
  int          m_wc   = 0;
  bit          m_pend = 0;
  bit          m_to   = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  logic [5:0]  snap_vec;
  logic [1:0]  snap_state;
  logic        snap_to;
  logic [31:0] snap_stall, snap_flush;

  function automatic logic [5:0] dut_vec();
    return {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef HAZARD_CTRL_PERF_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic snapshot();
    snap_vec   = dut_vec();
    snap_state = state;
    snap_to    = mem_timeout;
    snap_stall = stall_cnt;
    snap_flush = flush_cnt;
  endtask

  // One pipeline cycle: drive, compare against the model, then advance the model at the edge.
  task automatic cyc(input logic a_req, a_rdy, a_br, a_oe, a_u1, a_u2,
                     input logic [4:0] a_rs1, a_rs2, a_rd);
    bit         lu, busy;
    logic [5:0] exp_v;
    @(negedge clk);
    req = a_req; rdy = a_rdy; br = a_br; oe = a_oe;
    u1 = a_u1; u2 = a_u2; rs1 = a_rs1; rs2 = a_rs2; rd = a_rd;
    #1;
    lu = a_oe && (a_rd != 0) && ((a_u1 && a_rs1 == a_rd) || (a_u2 && a_rs2 == a_rd));
    busy = (m_mode == 2) || (m_mode == 1 && !a_rdy) || (m_mode == 0 && a_req && !a_rdy);
    exp_v = 6'b000000;
    if (busy)                             exp_v = 6'b111100;
    else if (a_br || (m_mode == 1 && m_pend)) exp_v = 6'b000011;
    else if (lu)                          exp_v = 6'b110001;
    snapshot();
    chk("ctrl_vec",  {26'd0, snap_vec}, {26'd0, exp_v});
    chk("state",     {30'd0, snap_state}, m_mode);
    chk("timeout",   {31'd0, snap_to}, {31'd0, m_to});
    chk("stall_cnt", snap_stall, exp_cnt(m_stall));
    chk("flush_cnt", snap_flush, exp_cnt(m_flush));
    $display("[TB] t=%0t req=%0b rdy=%0b br=%0b lu=%0b -> ctrl=%06b st=%0d to=%0b",
             $time, a_req, a_rdy, a_br, lu, snap_vec, snap_state, snap_to);
    @(posedge clk);
    m_stall += exp_v[5];
    m_flush += exp_v[0];
    if (m_mode == 0 && busy) begin
      m_mode = 1;
      m_wc   = 0;
    end else if (m_mode == 1) begin
      if (!a_rdy) begin
        m_pend = m_pend | a_br;
        m_wc++;
        if (m_wc == 256) begin
          m_mode = 2;
          m_to   = 1;
        end
      end else begin
        m_mode = 0;
        m_pend = 0;
      end
    end
  endtask

  task automatic idle();
    cyc(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // Assert reset at a negedge with hostile inputs; outputs must clear at once.
  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = 1'b1;
      req = 1'b1; rdy = 1'b0; br = 1'b1; oe = 1'b1; u1 = 1'b1; rs1 = 5'd3; rd = 5'd3;
      #1;
      m_mode = 0; m_wc = 0; m_pend = 0; m_to = 0; m_stall = 0; m_flush = 0;
      chk("rst_vec",   {26'd0, dut_vec()}, 32'd0);
      chk("rst_state", {30'd0, state}, 32'd0);
      chk("rst_to",    {31'd0, mem_timeout}, 32'd0);
      chk("rst_stall", stall_cnt, 32'd0);
      chk("rst_flush", flush_cnt, 32'd0);
      $display("[TB] t=%0t reset cycle %0d", $time, k);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    do_reset(2);

    // Load-use: lw x5 in EX, add x6,x5,x7 in ID.
    cyc(0, 1, 0, 1, 1, 1, 5'd5, 5'd7, 5'd5);
    chk("lu_bubble", {26'd0, snap_vec}, 32'b110001);
    idle();
    chk("lu_after", {26'd0, snap_vec}, 32'd0);
    cyc(0, 1, 0, 1, 1, 0, 5'd0, 5'd7, 5'd0);
    chk("lu_x0", {26'd0, snap_vec}, 32'd0);

    // Memory wait of three cycles with a branch in the middle of it.
    cyc(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("mw_c1", {26'd0, snap_vec}, 32'b111100);
    cyc(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("mw_c2_state", {30'd0, snap_state}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("mw_c3", {26'd0, snap_vec}, 32'b111100);
    cyc(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("mw_exit", {26'd0, snap_vec}, 32'b000011);
    idle();
    chk("mw_run", {30'd0, snap_state}, 32'd0);
    chk("mw_quiet", {26'd0, snap_vec}, 32'd0);
`ifdef HAZARD_CTRL_PERF_EN
    chk("perf_stall", snap_stall, 32'd4);
    chk("perf_flush", snap_flush, 32'd2);
`else
    chk("perf_stall", snap_stall, 32'd0);
    chk("perf_flush", snap_flush, 32'd0);
`endif

    // Branch in RUN.
    cyc(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("br_flush", {26'd0, snap_vec}, 32'b000011);
    idle();
    chk("br_once", {26'd0, snap_vec}, 32'd0);

    // Everything at once: memory wait wins.
    cyc(1, 0, 1, 1, 1, 0, 5'd9, 5'd0, 5'd9);
    chk("prio_vec", {26'd0, snap_vec}, 32'b111100);
    cyc(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("prio_state", {30'd0, snap_state}, 32'd1);
    chk("prio_exit", {26'd0, snap_vec}, 32'd0);

    // Watchdog: memory never answers.
    cyc(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < 256; k++) cyc(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("wd_last_wait", {30'd0, snap_state}, 32'd1);
    cyc(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("wd_state", {30'd0, snap_state}, 32'd2);
    chk("wd_flag", {31'd0, snap_to}, 32'd1);
    chk("wd_holds", {26'd0, snap_vec}, 32'b111100);
    idle();
    do_reset(1);

    // Randomized traffic with small register space so hazards are frequent.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
- i_id_rs1_addr, i_id_rs2_addr  in  5  source registers of the instruction in ID.
- i_id_rs1_used, i_id_rs2_used  in  1  ID instruction reads rs1 / rs2.
- i_ex_rd_addr  in  5  destination register of the instruction in EX.
- i_ex_DM_OE  in  1  EX instruction is a load.
- i_ex_branch_taken  in  1  EX instruction redirects the PC.
- i_dm_req  in  1  MEM stage has a data-memory access outstanding.
- i_dm_ready  in  1  data memory completes the access this cycle.
- o_pc_hold, o_if_id_hold, o_id_ex_hold, o_ex_mem_hold  out  1  freeze the PC and the named pipeline registers.
- o_if_id_flush, o_id_ex_flush  out  1  load a bubble (all-zero) into IF/ID or ID/EX.
- o_state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 TIMEOUT.
- o_mem_timeout  out  1  sticky watchdog flag.
- o_stall_cnt, o_flush_cnt  out  32  performance counters (REQ-016).

Function
REQ-002 The load-use condition SHALL be: i_ex_DM_OE=1, i_ex_rd_addr!=0, and (i_id_rs1_used and rs1==rd, or i_id_rs2_used and rs2==rd).
REQ-003 In RUN, on load-use with no memory wait or branch, the block SHALL assert o_pc_hold, o_if_id_hold and o_id_ex_flush in the same cycle, inserting exactly one bubble, and stay in RUN.
REQ-004 In RUN, on i_ex_branch_taken=1 with no memory wait, the block SHALL assert o_if_id_flush and o_id_ex_flush for that cycle only and no holds; a simultaneous load-use is ignored.
REQ-005 In RUN, on i_dm_req=1 and i_dm_ready=0, the block SHALL assert all four holds combinationally in that cycle and go to MEM_WAIT.
REQ-006 In MEM_WAIT, all four holds SHALL stay asserted while i_dm_ready=0; both flushes and the load-use response are suppressed.
REQ-007 In MEM_WAIT, a cycle with i_ex_branch_taken=1 SHALL set the pending_flush register.
REQ-008 In MEM_WAIT with i_dm_ready=1, all holds SHALL deassert and the state returns to RUN.
REQ-009 In that exit cycle, both flushes SHALL assert if pending_flush or i_ex_branch_taken is 1; otherwise a load-use SHALL be handled per REQ-003. pending_flush clears in the exit cycle.
REQ-010 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle with i_dm_ready=0, saturating at 255.
REQ-011 When the wait counter reaches 255 with i_dm_ready still 0, the block SHALL go to TIMEOUT and set o_mem_timeout.
REQ-012 TIMEOUT SHALL keep all holds asserted and is left only by reset.
REQ-013 Priority SHALL be: memory wait > branch flush > load-use.
REQ-014 Outputs SHALL be combinational from state, registers and inputs; state, pending_flush, wait counter, flag and counters are registered.

Reset
REQ-015 While rst is high, the block SHALL be in RUN with pending_flush=0, wait counter=0, o_mem_timeout=0 and counters=0; all holds and flushes are 0. Reset asserted mid-MEM_WAIT or in TIMEOUT takes effect immediately.

Configuration
REQ-016 With macro HAZARD_CTRL_PERF_EN defined, o_stall_cnt SHALL increment (wrapping at 2^32) every cycle o_pc_hold=1, and o_flush_cnt SHALL increment every cycle o_id_ex_flush=1. Without the macro, both outputs are constant 0 and no counter flops exist.

Verification
REQ-017 Load-use: EX lw to x5 with ID add x6,x5,x7 -> one cycle with pc_hold=if_id_hold=id_ex_flush=1, then normal flow; with rd=x0 -> no stall.
REQ-018 Branch: branch_taken=1 for 1 cycle in RUN -> if_id_flush=id_ex_flush=1 for exactly 1 cycle, holds 0.
REQ-019 Memory wait: dm_req=1, dm_ready=0 for 3 cycles then 1 -> all holds 1 for 3 cycles, o_state=1, RUN in cycle 4; branch_taken=1 during the wait -> both flushes in the exit cycle only.
REQ-020 Timeout: dm_req=1, dm_ready held 0 -> o_state=2 and o_mem_timeout=1 after 256 wait cycles; stays there until rst, then all outputs 0.
REQ-021 Priority: load-use, branch and dm wait asserted together -> holds only, no flush, state MEM_WAIT.
REQ-022 With HAZARD_CTRL_PERF_EN: REQ-017 and REQ-019 sequences -> o_stall_cnt=4, o_flush_cnt=2; without the macro, both read 0.
